// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller.
// Provides the phase encoding and fixed phase/clamp lengths in ticks.
package traffic_pkg;

    typedef enum logic [1:0] {
        S_RED        = 2'd0,
        S_RED_YELLOW = 2'd1,
        S_GREEN      = 2'd2,
        S_YELLOW     = 2'd3
    } state_t;

    localparam int unsigned RED_YELLOW_TICKS = 1;
    localparam int unsigned PED_GREEN_CLAMP  = 2;

endpackage

// File: rtl/tick_prescaler.sv
// Registered mod-k tick source: o_tick is high for one cycle after each wrap.
// Ports: i_clk, i_reset (sync, high), i_enable, i_k (0 means 2^N), o_tick.
module tick_prescaler #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_enable,
    input  logic [N-1:0] i_k,
    output logic         o_tick
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] count;
    logic [N-1:0] last;

    // k=0 underflows to all-ones, giving a full 2^N period.
    assign last = i_k - ONE;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count  <= '0;
            o_tick <= 1'b0;
        end else if (i_enable) begin
            if (count == last) begin
                count  <= '0;
                o_tick <= 1'b1;
            end else begin
                count  <= count + ONE;
                o_tick <= 1'b0;
            end
        end else begin
            o_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Traffic light sequencer RED -> RED_YELLOW -> GREEN -> YELLOW with ped request.
// Ports: i_clk, i_reset, i_enable, i_k, i_t_*, i_ped_req; lamps, walk, ack, state.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int N = 8,
    parameter int T = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_enable,
    input  logic [N-1:0] i_k,
    input  logic [T-1:0] i_t_red,
    input  logic [T-1:0] i_t_green,
    input  logic [T-1:0] i_t_yellow,
    input  logic         i_ped_req,
    output logic         o_red,
    output logic         o_yellow,
    output logic         o_green,
    output logic         o_ped_walk,
    output logic         o_ped_ack,
    output logic [1:0]   o_state
);

    localparam logic [T-1:0] ONE   = {{(T-1){1'b0}}, 1'b1};
    localparam logic [T-1:0] CLAMP = T'(PED_GREEN_CLAMP);
    localparam logic [T-1:0] RY_T  = T'(RED_YELLOW_TICKS);

    state_t       state;
    logic [T-1:0] timer;
    logic         latch;
    logic         tick;
    logic         step;
    logic         expire;
    logic         pend;
    logic         serve;
    logic         clamp;

    function automatic logic [T-1:0] at_least_one(input logic [T-1:0] t);
        return (t == '0) ? ONE : t;
    endfunction

    tick_prescaler #(.N(N)) u_presc (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_k      (i_k),
        .o_tick   (tick)
    );

    // A tick arriving while disabled is dropped so the timer stays frozen.
    assign step   = i_enable & tick;
    assign expire = step & (timer == ONE);
    assign pend   = latch | i_ped_req;
    assign serve  = expire & (state == S_YELLOW) & pend;
    assign clamp  = i_enable & (state == S_GREEN) & latch & (timer > CLAMP);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_RED;
            timer      <= at_least_one(i_t_red);
            latch      <= 1'b0;
            o_ped_walk <= 1'b0;
            o_ped_ack  <= 1'b0;
        end else begin
            o_ped_ack <= serve;
            latch     <= serve ? 1'b0 : pend;
            if (clamp) begin
                // Clamp wins over this cycle's tick decrement.
                timer <= CLAMP;
            end else if (expire) begin
                unique case (state)
                    S_RED: begin
                        state      <= S_RED_YELLOW;
                        timer      <= RY_T;
                        o_ped_walk <= 1'b0;
                    end
                    S_RED_YELLOW: begin
                        state <= S_GREEN;
                        timer <= at_least_one(i_t_green);
                    end
                    S_GREEN: begin
                        state <= S_YELLOW;
                        timer <= at_least_one(i_t_yellow);
                    end
                    S_YELLOW: begin
                        state <= S_RED;
                        timer <= at_least_one(i_t_red);
                        if (serve) begin
                            o_ped_walk <= 1'b1;
                        end
                    end
                endcase
            end else if (step) begin
                timer <= timer - ONE;
            end
        end
    end

    assign o_red    = (state == S_RED) | (state == S_RED_YELLOW);
    assign o_yellow = (state == S_RED_YELLOW) | (state == S_YELLOW);
    assign o_green  = (state == S_GREEN);
    assign o_state  = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Testbench for traffic_light_ctrl: vector table, directed corners, random vs model.
// Ports: none; drives the DUT and prints a single summary line.
module tb_traffic_light_ctrl;

    localparam int N = 8;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b1;
    logic [N-1:0] k = 8'd1;
    logic [T-1:0] t_red = 4'd2;
    logic [T-1:0] t_green = 4'd3;
    logic [T-1:0] t_yellow = 4'd2;
    logic         ped = 1'b0;
    logic         red, yellow, green, walk, ack;
    logic [1:0]   state;

    int checks = 0;
    int errors = 0;
    int cur = 0;

    traffic_light_ctrl #(.N(N), .T(T)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_enable   (enable),
        .i_k        (k),
        .i_t_red    (t_red),
        .i_t_green  (t_green),
        .i_t_yellow (t_yellow),
        .i_ped_req  (ped),
        .o_red      (red),
        .o_yellow   (yellow),
        .o_green    (green),
        .o_ped_walk (walk),
        .o_ped_ack  (ack),
        .o_state    (state)
    );

    always #5 clk = ~clk;

    // Reference model: phase index 0..3, remaining ticks, integer prescaler.
    int m_phase, m_rem, m_cnt;
    bit m_tick, m_latch, m_walk, m_ack;

    function automatic int len1(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    function automatic int phase_len(input int p);
        case (p)
            0: return len1(int'(t_red));
            1: return 1;
            2: return len1(int'(t_green));
            default: return len1(int'(t_yellow));
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_rem   <= len1(int'(t_red));
            m_cnt   <= 0;
            m_tick  <= 0;
            m_latch <= 0;
            m_walk  <= 0;
            m_ack   <= 0;
        end else begin : mdl
            int div;
            bit stp, pend;
            div  = (k == 0) ? (1 << N) : int'(k);
            pend = m_latch || ped;
            stp  = enable && m_tick;
            if (enable) begin
                if (m_cnt == div - 1) begin
                    m_cnt  <= 0;
                    m_tick <= 1;
                end else begin
                    m_cnt  <= (m_cnt + 1) % (1 << N);
                    m_tick <= 0;
                end
            end else begin
                m_tick <= 0;
            end
            m_ack <= 0;
            if (enable && m_phase == 2 && m_latch && m_rem > 2) begin
                m_rem <= 2;
            end else if (stp && m_rem == 1) begin
                m_phase <= (m_phase + 1) % 4;
                m_rem   <= phase_len((m_phase + 1) % 4);
                if (m_phase == 3 && pend) begin
                    m_walk <= 1;
                    m_ack  <= 1;
                    pend   = 0;
                end
                if (m_phase == 0) m_walk <= 0;
            end else if (stp) begin
                m_rem <= m_rem - 1;
            end
            m_latch <= pend;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d",
                     nm, cur, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("m_state", 32'(state), 32'(m_phase));
        chk("m_red", 32'(red), 32'(m_phase < 2));
        chk("m_yellow", 32'(yellow), 32'(m_phase == 1 || m_phase == 3));
        chk("m_green", 32'(green), 32'(m_phase == 2));
        chk("m_walk", 32'(walk), 32'(m_walk));
        chk("m_ack", 32'(ack), 32'(m_ack));
    endtask

    task automatic do_reset(input int kk, input int tr, input int tg,
                            input int ty);
        @(negedge clk);
        k        = N'(kk);
        t_red    = T'(tr);
        t_green  = T'(tg);
        t_yellow = T'(ty);
        ped      = 1'b0;
        enable   = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cur   = 0;
    endtask

    task automatic step_to(input int c);
        while (cur < c) begin
            @(negedge clk);
            cur++;
        end
    endtask

    typedef struct {
        int k;
        int cyc;
        int st;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // k=1: RED 0-2, RY 3, GREEN 4-6, YELLOW 7-8, RED 9-10
        for (int c = 0; c <= 10; c++) begin
            int s;
            s = (c <= 2) ? 0 : (c == 3) ? 1 : (c <= 6) ? 2 : (c <= 8) ? 3 : 0;
            vecs.push_back('{k: 1, cyc: c, st: s});
        end
        // k=3: RED 0-6, RY 7-9, GREEN 10
        for (int c = 0; c <= 10; c++) begin
            int s;
            s = (c <= 6) ? 0 : (c <= 9) ? 1 : 2;
            vecs.push_back('{k: 3, cyc: c, st: s});
        end

        foreach (vecs[i]) begin
            if (vecs[i].cyc == 0) begin
                do_reset(vecs[i].k, 2, 3, 2);
                chk("rst_walk", 32'(walk), 0);
                chk("rst_ack", 32'(ack), 0);
            end
            step_to(vecs[i].cyc);
            chk("tbl_state", 32'(state), 32'(vecs[i].st));
            chk("tbl_red", 32'(red), 32'(vecs[i].st < 2));
            chk("tbl_yellow", 32'(yellow),
                32'(vecs[i].st == 1 || vecs[i].st == 3));
            chk("tbl_green", 32'(green), 32'(vecs[i].st == 2));
        end

        // Pedestrian request shortens GREEN and is served in next RED.
        do_reset(1, 2, 8, 2);
        step_to(5);
        ped = 1'b1;
        step_to(6);
        ped = 1'b0;
        step_to(8);
        chk("ped_green_end", 32'(state), 2);
        step_to(9);
        chk("ped_yellow", 32'(state), 3);
        step_to(10);
        chk("ped_no_walk_yel", 32'(walk), 0);
        step_to(11);
        chk("ped_red", 32'(state), 0);
        chk("ped_ack1", 32'(ack), 1);
        chk("ped_walk1", 32'(walk), 1);
        step_to(12);
        chk("ped_ack0", 32'(ack), 0);
        chk("ped_walk_hold", 32'(walk), 1);
        step_to(13);
        chk("ped_ry", 32'(state), 1);
        chk("ped_walk_off", 32'(walk), 0);

        // Freeze mid-GREEN for 5 cycles.
        do_reset(1, 2, 8, 2);
        step_to(6);
        enable = 1'b0;
        for (int c = 7; c <= 10; c++) begin
            step_to(c);
            chk("frz_green", 32'(state), 2);
        end
        step_to(11);
        enable = 1'b1;
        step_to(17);
        chk("frz_still_green", 32'(state), 2);
        step_to(18);
        chk("frz_yellow", 32'(state), 3);

        // k=0 and all lengths 0: one tick per phase, 256-cycle ticks.
        do_reset(0, 0, 0, 0);
        step_to(256);
        chk("k0_red", 32'(state), 0);
        step_to(257);
        chk("k0_ry", 32'(state), 1);
        step_to(512);
        chk("k0_ry_end", 32'(state), 1);
        step_to(513);
        chk("k0_green", 32'(state), 2);
        step_to(769);
        chk("k0_yellow", 32'(state), 3);
        step_to(1025);
        chk("k0_red2", 32'(state), 0);

        // Reset during YELLOW with a pending request.
        do_reset(1, 2, 3, 2);
        step_to(5);
        ped = 1'b1;
        step_to(6);
        ped = 1'b0;
        step_to(7);
        chk("ry_yellow", 32'(state), 3);
        reset = 1'b1;
        step_to(8);
        chk("ry_red", 32'(state), 0);
        chk("ry_walk", 32'(walk), 0);
        chk("ry_ack", 32'(ack), 0);
        reset = 1'b0;
        cur = 0;
        step_to(9);
        chk("ry_red2", 32'(state), 0);
        chk("ry_no_serve", 32'(walk), 0);

        // Randomized run against the reference model.
        do_reset(2, 2, 3, 2);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            cur++;
            chk_model();
            if (i % 300 == 299) begin
                k        = N'($urandom_range(1, 5));
                t_red    = T'($urandom_range(0, 5));
                t_green  = T'($urandom_range(0, 6));
                t_yellow = T'($urandom_range(0, 5));
            end
            enable = ($urandom_range(0, 99) < 85);
            ped    = ($urandom_range(0, 99) < 8);
            reset  = ($urandom_range(0, 399) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
